// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams configuration words LSB-first into a ccff chain,
// exactly CHAIN_LEN bits per load, and repacks the bits returned on ccff_tail
// into readback words.
//
// Handshake: cfg_data is transferred on a rising prog_clk edge where
// cfg_valid and cfg_ready are both high; cfg_ready is only high in FETCH.
// rb_valid is a single-cycle strobe with no back-pressure.
//
// All outputs are registered. Each output's next value is derived from the
// next FSM state, so ccff_head and ccff_shift_en change together on the same
// edge and stay stable for the whole shift cycle.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1152,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;     // remaining unshifted bits of the current word
    logic [WORD_W-1:0] mask_q, mask_d;     // one-hot position of the bit now on ccff_head
    logic [WORD_W-1:0] acc_q, acc_d;       // readback word being assembled
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_ready_q, cfg_ready_d;

    logic [WORD_W-1:0] acc_next;
    logic              last_bit;
    logic              word_end;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        mask_d     = mask_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        head_d     = head_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        acc_next   = acc_q | (ccff_tail ? mask_q : '0);
        last_bit   = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
        word_end   = mask_q[WORD_W-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    bit_cnt_d = '0;
                    acc_d     = '0;
                end
            end
            S_FETCH: begin
                if (cfg_valid && cfg_ready_q) begin
                    state_d = S_SHIFT;
                    head_d  = cfg_data[0];
                    word_d  = cfg_data >> 1;
                    mask_d  = WORD_W'(1);
                end
            end
            S_SHIFT: begin
                // The bit on ccff_head is consumed at the edge ending this cycle;
                // ccff_tail still shows the pre-shift chain output.
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit || word_end) begin
                    rb_data_d  = acc_next;
                    rb_valid_d = 1'b1;
                    acc_d      = '0;
                end else begin
                    acc_d = acc_next;
                end
                if (last_bit) begin
                    state_d = S_DONE;
                end else if (word_end) begin
                    state_d = S_FETCH;
                end else begin
                    head_d = word_q[0];
                    word_d = word_q >> 1;
                    mask_d = mask_q << 1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        shift_en_d  = (state_d == S_SHIFT);
        cfg_ready_d = (state_d == S_FETCH);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            mask_q      <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            rb_data_q   <= rb_data_d;
            rb_valid_q  <= rb_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a 10-bit chain and 8-bit words.
// The chain is modelled as a 10-bit shift register fed by ccff_head.
module tb_ccff_chain_loader;
  localparam int CL = 10;
  localparam int WW = 8;

  logic          prog_clk;
  logic          prog_reset;
  logic          start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // chain model: bit 0 takes ccff_head, tail is bit CL-1
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic      head_exp_q[$];
  logic [WW-1:0] rb_exp_q[$];
  int shift_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // monitor: sample outputs on the falling edge
  always @(negedge prog_clk) begin
    if (!prog_reset) begin
      if (ccff_shift_en) begin
        shift_cnt++;
        if (head_exp_q.size() == 0) chk("head_extra_shift", 32'd1, 32'd0);
        else chk("head_bit", {31'd0, ccff_head}, {31'd0, head_exp_q.pop_front()});
      end
      if (rb_valid) begin
        if (rb_exp_q.size() == 0) chk("rb_extra_word", 32'd1, 32'd0);
        else chk("rb_word", {24'd0, rb_data}, {24'd0, rb_exp_q.pop_front()});
      end
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  // queue expected head bits and the readback the chain model will return
  task automatic push_expect(input logic [CL-1:0] exp_head);
    logic [CL-1:0] seq;
    for (int i = 0; i < CL; i++) head_exp_q.push_back(exp_head[i]);
    for (int i = 0; i < CL; i++) seq[i] = chain[CL-1-i];
    rb_exp_q.push_back(seq[7:0]);
    rb_exp_q.push_back({6'd0, seq[9:8]});
    shift_cnt = 0;
    done_cnt = 0;
  endtask

  // wait for FETCH, hold cfg_valid low for gap cycles, then transfer one word
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    @(negedge prog_clk);
    while (!cfg_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("ready_timeout", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < gap; i++) begin
      @(negedge prog_clk);
      chk("stall_shift_en", {31'd0, ccff_shift_en}, 32'd0);
      chk("stall_ready", {31'd0, cfg_ready}, 32'd1);
    end
    cfg_data = w;
    cfg_valid = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_valid = 1'b0;
    cfg_data = $urandom_range(0, 255);
  endtask

  task automatic wait_done_and_check();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
    chk("final_rb_with_done", {31'd0, rb_valid}, 32'd1);
    @(negedge prog_clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("shift_count", shift_cnt, CL);
    chk("done_count", done_cnt, 32'd1);
    chk("head_q_drained", head_exp_q.size(), 32'd0);
    chk("rb_q_drained", rb_exp_q.size(), 32'd0);
  endtask

  task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input int gap, input logic [CL-1:0] exp_head, input logic mid_start);
    push_expect(exp_head);
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_word(w0, 0);
    if (mid_start) begin
      @(negedge prog_clk);
      chk("mid_in_shift", {31'd0, ccff_shift_en}, 32'd1);
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    send_word(w1, gap);
    wait_done_and_check();
  endtask

  typedef struct {
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    int            gap;
    logic [CL-1:0] exp_head;  // bit i = i-th bit driven on ccff_head
    logic          mid_start;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 8'h03, 0, 10'h3A5, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 0, 10'h000, 1'b0};
    vecs[2] = '{8'hA5, 8'h03, 5, 10'h3A5, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 0, 10'h300, 1'b0};
    vecs[4] = '{8'h5A, 8'h01, 0, 10'h15A, 1'b1};
    vecs[5] = '{8'h3C, 8'h02, 2, 10'h23C, 1'b0};

    prog_reset = 1'b1;
    start = 1'b0;
    cfg_data = '0;
    cfg_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_head", {31'd0, ccff_head}, 32'd0);
    chk("rst_shift_en", {31'd0, ccff_shift_en}, 32'd0);
    chk("rst_rb_data", {24'd0, rb_data}, 32'd0);
    chk("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    prog_reset = 1'b0;

    // 0: A5,03 then 1: readback A5,03; 2: stalled word; 3: 0xFF partial;
    // 4: readback last word 0x03 with a stray start; 5: short stall
    for (int i = 0; i < 6; i++)
      run_load(vecs[i].w0, vecs[i].w1, vecs[i].gap, vecs[i].exp_head, vecs[i].mid_start);

    // random loads: only w1[1:0] reaches the chain
    for (int i = 0; i < 3; i++) begin
      logic [WW-1:0] a;
      logic [WW-1:0] b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      run_load(a, b, $urandom_range(0, 3), {b[1:0], a}, 1'b0);
    end

    // reset part-way through a load
    begin
      int n;
      push_expect(10'h0C3);
      pulse_start();
      send_word(8'hC3, 0);
      n = 0;
      while (shift_cnt < 4 && n < 100) begin
        @(negedge prog_clk);
        n++;
      end
      chk("abort_reach_4_shifts", shift_cnt, 32'd4);
      #2 prog_reset = 1'b1;
      #1;
      chk("abort_shift_en", {31'd0, ccff_shift_en}, 32'd0);
      chk("abort_head", {31'd0, ccff_head}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      chk("abort_rb_valid", {31'd0, rb_valid}, 32'd0);
      chk("abort_rb_data", {24'd0, rb_data}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_state", {30'd0, dbg_state}, 32'd0);
      head_exp_q.delete();
      rb_exp_q.delete();
      @(negedge prog_clk);
      @(negedge prog_clk);
      chk("abort_no_done", done_cnt, 32'd0);
      prog_reset = 1'b0;
    end

    // full load after the abort
    run_load(8'h96, 8'h02, 1, 10'h296, 1'b0);
    run_load(8'h11, 8'h01, 0, 10'h111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
